// File: rtl/clock_presence_monitor.sv
// Verifies that the enabled clock-generator output is toggling at a plausible rate.
// Optional macro CLK_MON_STICKY_FAULT_EN latches FAULT until iRst_n.
module clock_presence_monitor #(
    parameter int SETTLE_CYCLES = 200,
    parameter int WINDOW_CYCLES = 64,
    parameter int MIN_EDGES     = 8,
    parameter int MAX_EDGES     = 24,
    parameter int FAULT_WINDOWS = 2,
    parameter int CNT_W         = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClkOeActive,
    input  logic             iMonClk,
    output logic             oClkGood,
    output logic             oClkFault,
    output logic [CNT_W-1:0] oLastEdgeCount
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int BAD_W = $clog2(FAULT_WINDOWS + 1);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [BAD_W-1:0] FAULT_LIMIT = BAD_W'(FAULT_WINDOWS);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_EDGES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        GOOD,
        FAULT
    } stateT;

    stateT            state, stateNext;
    logic [2:0]       monSync;
    logic [SET_W-1:0] settleCnt, settleNext;
    logic [WIN_W-1:0] winCnt, winNext;
    logic [CNT_W-1:0] edgeCnt, edgeNext, finalCount, lastNext;
    logic [BAD_W-1:0] badCnt, badNext;
    logic             edgePulse;
    logic             windowPass;
    logic             leave;

    assign edgePulse  = monSync[1] & ~monSync[2];
    assign finalCount = (edgeCnt == '1) ? edgeCnt : edgeCnt + CNT_W'(edgePulse);
    assign windowPass = (finalCount >= MIN_CNT) && (finalCount <= MAX_CNT);

`ifdef CLK_MON_STICKY_FAULT_EN
    assign leave = !iClkOeActive && (state != FAULT);
`else
    assign leave = !iClkOeActive;
`endif

    always_comb begin
        stateNext  = state;
        settleNext = settleCnt;
        winNext    = winCnt;
        edgeNext   = edgeCnt;
        badNext    = badCnt;
        lastNext   = oLastEdgeCount;
        case (state)
            IDLE: begin
                if (iClkOeActive) begin
                    stateNext  = SETTLE;
                    settleNext = '0;
                end
            end
            SETTLE: begin
                if (settleCnt == SETTLE_LAST) begin
                    stateNext = MEASURE;
                    winNext   = '0;
                    edgeNext  = '0;
                end else begin
                    settleNext = settleCnt + SET_W'(1);
                end
            end
            MEASURE, GOOD: begin
                edgeNext = finalCount;
                winNext  = winCnt + WIN_W'(1);
                if (winCnt == WIN_LAST) begin
                    winNext  = '0;
                    edgeNext = '0;
                    lastNext = finalCount;
                    if (windowPass) begin
                        badNext   = '0;
                        stateNext = GOOD;
                    end else begin
                        badNext = badCnt + BAD_W'(1);
                        if (badCnt + BAD_W'(1) == FAULT_LIMIT) begin
                            stateNext = FAULT;
                        end
                    end
                end
            end
            FAULT: ;
            default: stateNext = IDLE;
        endcase
        // Disable overrides everything, including a coinciding window evaluation.
        if (leave) begin
            stateNext  = IDLE;
            settleNext = '0;
            winNext    = '0;
            edgeNext   = '0;
            badNext    = '0;
            lastNext   = oLastEdgeCount;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state          <= IDLE;
            monSync        <= '0;
            settleCnt      <= '0;
            winCnt         <= '0;
            edgeCnt        <= '0;
            badCnt         <= '0;
            oLastEdgeCount <= '0;
            oClkGood       <= 1'b0;
            oClkFault      <= 1'b0;
        end else begin
            state          <= stateNext;
            monSync        <= {monSync[1:0], iMonClk};
            settleCnt      <= settleNext;
            winCnt         <= winNext;
            edgeCnt        <= edgeNext;
            badCnt         <= badNext;
            oLastEdgeCount <= lastNext;
            oClkGood       <= (state == GOOD) && !leave;
            oClkFault      <= (state == FAULT) && !leave;
        end
    end

endmodule
